// File: rtl/sram_drv_pkg.sv
// Shared state encoding, strobe encodings and defaults for the SRAM host driver.
package sram_drv_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, TAIL} drv_state_t;

  // Strobe encodings, ordered {we, oe, commit}.
  localparam logic [2:0] PULSE_WLO    = 3'b100;
  localparam logic [2:0] PULSE_WHI    = 3'b100;
  localparam logic [2:0] PULSE_COMMIT = 3'b001;
  localparam logic [2:0] PULSE_READ   = 3'b010;
  localparam logic [2:0] PULSE_SRST   = 3'b111;
  localparam logic [2:0] PULSE_STRM   = 3'b110;

  localparam int SRAM_DEPTH = 8;

endpackage

// File: rtl/sram_drv_phase_timer.sv
// Phase timer: phase_done marks the last cycle of every PHASE_CYCLES-long phase;
// start realigns the count so the next phase begins on the following cycle.
module sram_drv_phase_timer #(
  parameter int PHASE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic phase_done
);

  localparam logic [3:0] RELOAD = 4'(PHASE_CYCLES - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                     cnt <= 4'd0;
    else if (start || cnt == 4'd0) cnt <= RELOAD;
    else                           cnt <= cnt - 4'd1;
  end

  assign phase_done = (cnt == 4'd0);

endmodule

// File: rtl/sram_host_driver.sv
// Host sequencer for the nibble-serial SRAM tile: byte requests become sram_clk pulses and strobes.
// Define SRAM_DRV_STREAM_EN to turn reads into reset + stream bursts of req_len+1 bytes.
module sram_host_driver
  import sram_drv_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int DEPTH        = SRAM_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [2:0] req_len,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       sram_clk,
  output logic       sram_we,
  output logic       sram_oe,
  output logic       sram_commit,
  output logic [3:0] sram_ad,
  input  logic [7:0] sram_q
);

  drv_state_t state;
  logic [3:0] pulse_idx, last_idx;
  logic [2:0] cur_addr, adv_addr;
  logic [7:0] wdata_q;
  logic       is_write;
  logic       accept, phase_done;
  logic [6:0] acc_pins, adv_pins;

  function automatic logic [2:0] addr_wrap(input logic [3:0] a);
    return 3'(int'(a) % DEPTH);
  endfunction

  // Pins for pulse idx, packed {we, oe, commit, ad}.
  function automatic logic [6:0] pulse_pins(input logic wr, input logic [3:0] idx,
                                            input logic [2:0] a, input logic [7:0] wd);
    logic [6:0] p;
    p = {PULSE_READ, 1'b0, a};
    if (wr) begin
      case (idx)
        4'd0:    p = {PULSE_WLO, wd[3:0]};
        4'd1:    p = {PULSE_WHI, wd[7:4]};
        default: p = {PULSE_COMMIT, 1'b0, a};
      endcase
    end
`ifdef SRAM_DRV_STREAM_EN
    else if (idx == 4'd0) p = {PULSE_SRST, 1'b0, a};
    else                  p = {PULSE_STRM, 1'b0, a};
`endif
    return p;
  endfunction

`ifndef SRAM_DRV_STREAM_EN
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  assign accept = (state == IDLE) && req_ready && req_valid;

  // Stream pulses after the first one walk the address; writes and single reads never advance.
  always_comb begin
    adv_addr = cur_addr;
    if (!is_write && pulse_idx != 4'd0) adv_addr = addr_wrap({1'b0, cur_addr} + 4'd1);
  end

  assign acc_pins = pulse_pins(req_write, 4'd0, addr_wrap({1'b0, req_addr}), req_wdata);
  assign adv_pins = pulse_pins(is_write, pulse_idx + 4'd1, adv_addr, wdata_q);

  sram_drv_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      rsp_last    <= 1'b0;
      sram_clk    <= 1'b0;
      sram_we     <= 1'b0;
      sram_oe     <= 1'b0;
      sram_commit <= 1'b0;
      sram_ad     <= 4'h0;
      pulse_idx   <= 4'd0;
      last_idx    <= 4'd0;
      cur_addr    <= 3'd0;
      wdata_q     <= 8'h00;
      is_write    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= LOW;
            req_ready <= 1'b0;
            is_write  <= req_write;
            cur_addr  <= addr_wrap({1'b0, req_addr});
            wdata_q   <= req_wdata;
            pulse_idx <= 4'd0;
`ifdef SRAM_DRV_STREAM_EN
            last_idx  <= req_write ? 4'd2 : ({1'b0, req_len} + 4'd1);
`else
            last_idx  <= req_write ? 4'd2 : 4'd0;
`endif
            {sram_we, sram_oe, sram_commit, sram_ad} <= acc_pins;
          end
        end
        LOW: if (phase_done) begin
          state    <= HIGH;
          sram_clk <= 1'b1;
`ifdef SRAM_DRV_STREAM_EN
          // This LOW follows stream pulse pulse_idx-2, whose byte is now on sram_q.
          if (!is_write && pulse_idx >= 4'd2) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sram_q;
          end
`endif
        end
        HIGH: if (phase_done) begin
          sram_clk <= 1'b0;
          if (pulse_idx == last_idx) begin
            state <= TAIL;
          end else begin
            state     <= LOW;
            pulse_idx <= pulse_idx + 4'd1;
            cur_addr  <= adv_addr;
            {sram_we, sram_oe, sram_commit, sram_ad} <= adv_pins;
          end
        end
        TAIL: if (phase_done) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          {sram_we, sram_oe, sram_commit, sram_ad} <= 7'd0;
          if (!is_write) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sram_q;
            rsp_last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_host_driver.sv
// Bench for sram_host_driver: P=1 instance against a behavioural SRAM tile, plus a P=3 instance for phase timing.
module tb_sram_host_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

`ifdef SRAM_DRV_STREAM_EN
  localparam int         RD_LAT = 6;
  localparam logic [2:0] RD_LEN = 3'd0;
`else
  localparam int         RD_LAT = 4;
  localparam logic [2:0] RD_LEN = 3'd5;
`endif

  // Pins packed {sram_clk, we, oe, commit, ad, req_ready}, cycles T+1..
  localparam logic [8:0] WR_TAB [0:7] = '{
    9'b0_100_0101_0, 9'b1_100_0101_0, 9'b0_100_1010_0, 9'b1_100_1010_0,
    9'b0_001_0011_0, 9'b1_001_0011_0, 9'b0_001_0011_0, 9'b0_000_0000_1};
  localparam logic [8:0] RD_TAB [0:3] = '{
    9'b0_010_0011_0, 9'b1_010_0011_0, 9'b0_010_0011_0, 9'b0_000_0000_1};

  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [2:0] req_addr = 3'd0, req_len = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid, rsp_last;
  logic [7:0] rsp_data, sram_q;
  logic       sram_clk, sram_we, sram_oe, sram_commit;
  logic [3:0] sram_ad;

  logic       r3_valid = 1'b0, r3_write = 1'b0;
  logic [2:0] r3_addr = 3'd0, r3_len = 3'd0;
  logic [7:0] r3_wdata = 8'h00;
  logic       r3_ready, rsp3_valid, rsp3_last;
  logic [7:0] rsp3_data;
  logic       sclk3, we3, oe3, commit3;
  logic [3:0] ad3;

  sram_host_driver #(.PHASE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .sram_clk(sram_clk), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_commit(sram_commit), .sram_ad(sram_ad), .sram_q(sram_q));

  sram_host_driver #(.PHASE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
    .req_addr(r3_addr), .req_wdata(r3_wdata), .req_len(r3_len),
    .rsp_valid(rsp3_valid), .rsp_data(rsp3_data), .rsp_last(rsp3_last),
    .sram_clk(sclk3), .sram_we(we3), .sram_oe(oe3),
    .sram_commit(commit3), .sram_ad(ad3), .sram_q(8'h00));

  // Behavioural SRAM tile: lo/hi nibbles shift in on we, commit stores, oe reads,
  // we+oe+commit loads the stream pointer, we+oe streams one byte per pulse.
  logic [7:0] mem [8];
  logic [7:0] nib = 8'h00, q_reg = 8'h00;
  logic [2:0] ptr = 3'd0;
  always @(posedge sram_clk) begin
    if (sram_we && sram_oe && sram_commit) ptr = sram_ad[2:0];
    else if (sram_we && sram_oe) begin q_reg = mem[ptr]; ptr = ptr + 3'd1; end
    else if (sram_we)            nib = {sram_ad, nib[7:4]};
    else if (sram_commit)        mem[sram_ad[2:0]] = nib;
    else if (sram_oe)            q_reg = mem[sram_ad[2:0]];
  end
  assign sram_q = sram_oe ? q_reg : 8'h00;

  typedef struct {logic [7:0] data; logic last; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_extra: got data=%h last=%b at cyc %0d, required no response", rsp_data, rsp_last, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_data !== mon_e.data || rsp_last !== mon_e.last || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL rsp: got data=%h last=%b cyc=%0d, required data=%h last=%b cyc=%0d",
                   rsp_data, rsp_last, cyc, mon_e.data, mon_e.last, mon_e.cyc);
        end
      end
    end
    if (rsp3_valid) begin
      checks++; errors++;
      $display("FAIL rsp3_extra: got data=%h last=%b, required no response", rsp3_data, rsp3_last);
    end
  end

  // Issues one request on the P=1 port; returns at negedge T+1 with t = T.
  task automatic do_req(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input logic [2:0] len, output int t);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_len = len;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept: ready=%b after %0d cycles, required 1", req_ready, n);
    end
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_last, sram_clk, sram_we, sram_oe, sram_commit, sram_ad} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {req_ready, rsp_valid, rsp_data, rsp_last, sram_clk, sram_we, sram_oe, sram_commit, sram_ad});
    end
    checks++;
    if ({r3_ready, rsp3_valid, rsp3_data, rsp3_last, sclk3, we3, oe3, commit3, ad3} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs3: got %h, required 0",
               {r3_ready, rsp3_valid, rsp3_data, rsp3_last, sclk3, we3, oe3, commit3, ad3});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, r3_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 11", {req_ready, r3_ready});
    end
  endtask

  task automatic test_write();
    int t;
    do_req(1'b1, 3'd3, 8'hA5, 3'd0, t);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({sram_clk, sram_we, sram_oe, sram_commit, sram_ad, req_ready} !== WR_TAB[k-1]) begin
        errors++;
        $display("FAIL write_pins T+%0d: got %b, required %b", k,
                 {sram_clk, sram_we, sram_oe, sram_commit, sram_ad, req_ready}, WR_TAB[k-1]);
      end
      if (k < 8) @(negedge clk);
    end
  endtask

  task automatic test_read();
    int t;
    do_req(1'b0, 3'd3, 8'h00, RD_LEN, t);
    exp_q.push_back('{8'hA5, 1'b1, t + RD_LAT});
`ifndef SRAM_DRV_STREAM_EN
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({sram_clk, sram_we, sram_oe, sram_commit, sram_ad, req_ready} !== RD_TAB[k-1]) begin
        errors++;
        $display("FAIL read_pins T+%0d: got %b, required %b", k,
                 {sram_clk, sram_we, sram_oe, sram_commit, sram_ad, req_ready}, RD_TAB[k-1]);
      end
      if (k < 4) @(negedge clk);
    end
`endif
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || rsp_data !== 8'hA5) begin
      errors++;
      $display("FAIL read_drain_hold: outstanding=%0d rsp_data=%h, required 0 and a5", exp_q.size(), rsp_data);
      exp_q.delete();
    end
  endtask

  task automatic test_patterns();
    logic [2:0] a [3] = '{3'd1, 3'd7, 3'd0};
    logic [7:0] d [3] = '{8'h3C, 8'hFF, 8'h81};
    int t;
    for (int i = 0; i < 3; i++) do_req(1'b1, a[i], d[i], 3'd0, t);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, a[i], 8'h00, RD_LEN, t);
      exp_q.push_back('{d[i], 1'b1, t + RD_LAT});
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL patterns_drain: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int t, t2, n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'h96; req_len = 3'd0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    t = cyc;
    @(negedge clk);
    req_write = 1'b0; req_addr = 3'd7; req_wdata = 8'h00; req_len = RD_LEN;
    n = 0;
    while (!req_ready && n < 20) begin
      if (cyc == t + 5) begin
        checks++;
        if ({sram_commit, sram_ad} !== 5'b1_0101) begin
          errors++;
          $display("FAIL b2b_commit: got commit/ad=%b, required 10101", {sram_commit, sram_ad});
        end
      end
      @(negedge clk); n++;
    end
    checks++;
    if (!req_ready || cyc != t + 8) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b at T+%0d, required 1 at T+8", req_ready, cyc - t);
    end
    t2 = cyc;
    exp_q.push_back('{8'hFF, 1'b1, t2 + RD_LAT});
    @(negedge clk);
    req_valid = 1'b0;
    do_req(1'b0, 3'd5, 8'h00, RD_LEN, t);
    exp_q.push_back('{8'h96, 1'b1, t + RD_LAT});
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_req(1'b1, 3'd3, 8'h5A, 3'd0, t);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, sram_clk, sram_we, sram_oe, sram_commit, sram_ad} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_pins: got %b, required 0",
               {req_ready, sram_clk, sram_we, sram_oe, sram_commit, sram_ad});
    end
    reset = 1'b0;
    @(negedge clk);
    do_req(1'b0, 3'd3, 8'h00, RD_LEN, t);
    exp_q.push_back('{8'hA5, 1'b1, t + RD_LAT});
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_drain: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_phase3();
    int t, n;
    logic exp_clk, exp_rdy;
    @(negedge clk);
    r3_valid = 1'b1; r3_write = 1'b1; r3_addr = 3'd2; r3_wdata = 8'hC3; r3_len = 3'd0;
    n = 0;
    while (!r3_ready && n < 50) begin @(negedge clk); n++; end
    t = cyc;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) r3_valid = 1'b0;
      exp_clk = (k <= 18) && (((k - 1) / 3) % 2 == 1);
      exp_rdy = (k == 22);
      checks++;
      if ({sclk3, r3_ready} !== {exp_clk, exp_rdy} || cyc != t + k) begin
        errors++;
        $display("FAIL p3_clk_ready T+%0d: got %b, required %b", k, {sclk3, r3_ready}, {exp_clk, exp_rdy});
      end
      if (k == 13) begin
        checks++;
        if ({we3, oe3, commit3, ad3} !== 7'b001_0010) begin
          errors++;
          $display("FAIL p3_commit: got %b, required 0010010", {we3, oe3, commit3, ad3});
        end
      end
    end
  endtask

`ifdef SRAM_DRV_STREAM_EN
  task automatic test_stream();
    int t;
    for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 8'((i + 1) * 17), 3'd0, t);
    do_req(1'b0, 3'd6, 8'h00, 3'd3, t);
    exp_q.push_back('{8'h77, 1'b0, t + 6});
    exp_q.push_back('{8'h88, 1'b0, t + 8});
    exp_q.push_back('{8'h11, 1'b0, t + 10});
    exp_q.push_back('{8'h22, 1'b1, t + 12});
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    test_phase3();
`ifdef SRAM_DRV_STREAM_EN
    test_stream();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/sram_host_driver.md
# sram_host_driver

Host-side sequencer that sits directly upstream of the 8-byte nibble-serial SRAM tile and drives its pin protocol. It accepts byte-wide read and write requests on a valid/ready interface. It generates the SRAM's clock and its we/oe/commit strobes, and serialises write data onto the 4-bit shared address/data bus. Read bytes are returned on a one-cycle response strobe.

## Interface
Parameters:
- PHASE_CYCLES, 1: clk cycles per sram_clk phase (low or high); legal range 1..15.
- DEPTH, 8: number of SRAM bytes; addresses wrap modulo DEPTH.

Ports:
- clk  in  1  system clock; every register samples on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  driver idle; a request is accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  3  byte address.
- req_wdata  in  8  write byte.
- req_len  in  3  burst length minus 1; used only with the stream feature.
- rsp_valid  out  1  one-cycle read-data strobe; no backpressure.
- rsp_data  out  8  read byte; holds its value until the next rsp_valid.
- rsp_last  out  1  final byte of the transaction; qualified by rsp_valid.
- sram_clk  out  1  SRAM clock, generated from registers.
- sram_we, sram_oe, sram_commit  out  1 each  SRAM strobes.
- sram_ad  out  4  shared address/data nibble; bit 3 = 0 during address phases.
- sram_q  in  8  SRAM output; valid only while sram_oe = 1.

## Operation
- Reset: all outputs are 0, including req_ready and rsp_data. The FSM enters IDLE. req_ready rises the cycle after reset deasserts.
- FSM states: IDLE, LOW, HIGH, TAIL. Pulse index and byte counter are registered beside the state.
- **Pulse:** one LOW phase followed by one HIGH phase.
  - sram_clk = 1 only in HIGH.
  - Strobes and sram_ad change only when entering LOW, and are held through HIGH.
- **Write:** three pulses.
  1. we = 1, ad = wdata[3:0]
  2. we = 1, ad = wdata[7:4]
  3. commit = 1, ad = {0, addr}
- **Read:** one pulse with oe = 1, ad = {0, addr}.
- **TAIL:** one phase after the last pulse. sram_clk = 0 and the strobes of the last pulse are held. For reads, sram_q is registered on the final cycle of TAIL.
- **Return to IDLE:** all strobes and ad go to 0, and req_ready = 1.
- req_valid is ignored while req_ready = 0. Request fields are captured at acceptance; later changes have no effect.
- Reset mid-transaction: the next cycle has all pins 0, and the FSM is in IDLE. No commit is ever issued for an aborted write, so the SRAM contents are unchanged.
- rsp_last = rsp_valid for single reads.

## Timing
All values below use P = PHASE_CYCLES; the handshake occurs in cycle T.
- First LOW phase starts at T+1.
- Write: req_ready = 1 again at T+1+7P; no response is generated.
- Read: rsp_valid and rsp_data at T+1+3P; req_ready = 1 in the same cycle.
- sram_clk high time = P, period = 2P.
- Back-to-back requests: the earliest next acceptance is the cycle req_ready rises.

## Configuration
- SRAM_DRV_STREAM_EN defined, read transactions become bursts:
  - One reset pulse: we = oe = commit = 1, ad = {0, addr}.
  - Then req_len+1 stream pulses with we = oe = 1; oe stays high throughout.
  - Byte k is sampled on the final cycle of the LOW phase (or TAIL) that follows stream pulse k.
  - rsp_valid for byte k comes one cycle after that sample; rsp_last accompanies the last byte.
  - Addresses wrap 7 -> 0.
  - Single read = req_len 0, with latency T+1+5P.
- SRAM_DRV_STREAM_EN undefined: req_len is ignored, reads use the single-pulse sequence, and the port remains present.

## Structure
- Package sram_drv_pkg holds:
  - the state enum;
  - the strobe-encoding constants (PULSE_WLO, PULSE_WHI, PULSE_COMMIT, PULSE_READ, PULSE_SRST, PULSE_STRM);
  - the default DEPTH.
- Sub-module sram_drv_phase_timer is a down-counter that emits phase_done every PHASE_CYCLES cycles and restarts on its start input.

## Test plan
- Write 0xA5 to addr 3, P = 1 -> three pulses with (we, ad) = (1, 0x5), (1, 0xA), then commit with ad = 0x3; req_ready at T+8.
- Read addr 3 against a behavioural SRAM model, after the write above -> rsp_data = 0xA5 and rsp_valid at T+4, rsp_last = 1.
- Stream enabled: preload 0x11..0x88 at addresses 0..7, then a read from addr 6 with req_len = 3 -> 0x77, 0x88, 0x11, 0x22, with rsp_last only on 0x22.
- req_valid held high throughout a write with a different request -> only the first request is issued, and the second is accepted at T+8.
- Reset asserted during the second write pulse -> all pins 0 next cycle; a subsequent read returns the old byte.
- P = 3 write -> sram_clk high 3 cycles and low 3 cycles; req_ready at T+22.
